// File: rtl/h80bus_pkg.sv
// h80bus_pkg: shared h80 bus command encodings, read-type helper and arbiter state type.
package h80bus_pkg;
    localparam logic [2:0] bus_cmd_write   = 3'd0;
    localparam logic [2:0] bus_cmd_read    = 3'd1;
    localparam logic [2:0] bus_cmd_write_w = 3'd2;
    localparam logic [2:0] bus_cmd_read_w  = 3'd3;
    localparam logic [2:0] bus_cmd_write_b = 3'd4;
    localparam logic [2:0] bus_cmd_read_b  = 3'd5;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DATA} arb_state_e;

    // Every read command has an odd encoding.
    function automatic logic is_read(input logic [2:0] cmd);
        return cmd[0];
    endfunction
endpackage

// File: rtl/h80bus_rr_grant.sv
// h80bus_rr_grant: combinational 2-way round-robin picker; a tie goes to the master not granted last.
module h80bus_rr_grant (
    input  logic [1:0] req_i,
    input  logic       rr_last_i,
    output logic       grant_valid_o,
    output logic       grant_idx_o
);
    assign grant_valid_o = |req_i;
    assign grant_idx_o   = (&req_i) ? ~rr_last_i : req_i[1];
endmodule

// File: rtl/h80bus_arbiter.sv
// h80bus_arbiter: two-master round-robin arbiter for the h80 memory bus with
// ACCESS/DATA sequencing, slave wait states and a wait timeout abort.
module h80bus_arbiter
    import h80bus_pkg::*;
#(
    parameter int BUS_ADDR_WIDTH = 16,
    parameter int BUS_CMD_WIDTH  = 3,
    parameter int BUS_DATA_WIDTH = 32,
    parameter int WAIT_TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      m0_req,
    input  logic [BUS_ADDR_WIDTH-1:0] m0_addr,
    input  logic [BUS_CMD_WIDTH-1:0]  m0_cmd,
    input  logic [BUS_DATA_WIDTH-1:0] m0_wdata,
    output logic                      m0_ack,
    output logic                      m0_err,
    output logic [BUS_DATA_WIDTH-1:0] m0_rdata,
    input  logic                      m1_req,
    input  logic [BUS_ADDR_WIDTH-1:0] m1_addr,
    input  logic [BUS_CMD_WIDTH-1:0]  m1_cmd,
    input  logic [BUS_DATA_WIDTH-1:0] m1_wdata,
    output logic                      m1_ack,
    output logic                      m1_err,
    output logic [BUS_DATA_WIDTH-1:0] m1_rdata,
    output logic                      ce_n,
    output logic [BUS_ADDR_WIDTH-1:0] addr,
    output logic [BUS_CMD_WIDTH-1:0]  cmd,
    inout  wire  [BUS_DATA_WIDTH-1:0] data_,
    input  logic                      wait_n
);
    localparam int CW = $clog2(WAIT_TIMEOUT + 1);

    arb_state_e              state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    rr_last_q, rr_last_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [1:0]              err_q, err_d;
    logic                    grant_valid, grant_idx;
    logic                    busy, own_read;
    logic [BUS_ADDR_WIDTH-1:0] own_addr;
    logic [BUS_CMD_WIDTH-1:0]  own_cmd;
    logic [BUS_DATA_WIDTH-1:0] own_wdata;

    h80bus_rr_grant u_grant (
        .req_i         ({m1_req, m0_req}),
        .rr_last_i     (rr_last_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    assign busy      = state_q != ST_IDLE;
    assign own_addr  = owner_q ? m1_addr : m0_addr;
    assign own_cmd   = owner_q ? m1_cmd : m0_cmd;
    assign own_wdata = owner_q ? m1_wdata : m0_wdata;
    assign own_read  = is_read(3'(own_cmd));

    assign ce_n  = !busy;
    assign addr  = busy ? own_addr : '0;
    assign cmd   = busy ? own_cmd : '0;
    // Writes stay on the bus through DATA; the slave tolerates the repeated strobe.
    assign data_ = (busy && !own_read) ? own_wdata : 'z;

    assign m0_ack   = state_q == ST_DATA && !owner_q;
    assign m1_ack   = state_q == ST_DATA && owner_q;
    assign m0_rdata = (m0_ack && own_read) ? data_ : '0;
    assign m1_rdata = (m1_ack && own_read) ? data_ : '0;
    assign m0_err   = err_q[0];
    assign m1_err   = err_q[1];

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        cnt_d     = cnt_q;
        err_d     = '0;
        if (state_q == ST_IDLE && grant_valid) begin
            state_d   = ST_ACCESS;
            owner_d   = grant_idx;
            rr_last_d = grant_idx;
        end else if (state_q == ST_ACCESS) begin
            if (wait_n) begin
                state_d = ST_DATA;
                cnt_d   = '0;
            end else if (cnt_q == CW'(WAIT_TIMEOUT - 1)) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                err_d   = owner_q ? 2'b10 : 2'b01;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (state_q == ST_DATA) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            cnt_q     <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_h80bus_arbiter.sv
// tb_h80bus_arbiter: directed and randomized checks of h80bus_arbiter against a slave model,
// a reference memory and a plain round-robin grant model.
module tb_h80bus_arbiter;
    import h80bus_pkg::*;

    localparam logic [31:0] KEEP = 32'h5A5A_C3C3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [15:0] m0_addr = '0, m1_addr = '0;
    logic [2:0]  m0_cmd = '0, m1_cmd = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ce_n;
    logic [15:0] addr;
    logic [2:0]  cmd;
    wire  [31:0] data_;
    logic        wait_n = 1'b1;
    logic        mem_init = 1'b0;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic        tb_oe;
    logic [31:0] tb_val;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    h80bus_arbiter #(.WAIT_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_cmd(m0_cmd), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_cmd(m1_cmd), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .ce_n(ce_n), .addr(addr), .cmd(cmd), .data_(data_), .wait_n(wait_n)
    );

    function automatic logic [31:0] pat(input int i);
        return (i == 16) ? 32'h0000BEEF : {16'hD00D, 8'(i), 8'(~i)};
    endfunction

    // Slave (word addressed) plus a bus keeper: the bench drives data_ whenever the
    // arbiter must not, so any stray arbiter drive corrupts the observed value.
    always_comb begin
        tb_oe  = ce_n || cmd[0];
        tb_val = ce_n ? KEEP : mem[addr[8:1]];
    end
    assign data_ = tb_oe ? tb_val : 'z;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        end else if (!ce_n && wait_n && !cmd[0]) begin
            mem[addr[8:1]] <= data_;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_init = 1'b1; m0_req = 1'b0; m1_req = 1'b0; wait_n = 1'b1;
        step(); step();
        reset = 1'b0; mem_init = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_init = 1'b1;
        step(); step();
        checks++; if (ce_n !== 1'b1) begin failures++; $display("FAIL reset_ce_n got=%b exp=1", ce_n); end
        checks++; if ({addr, cmd} !== 19'd0) begin failures++; $display("FAIL reset_addr_cmd got=%h/%h exp=0", addr, cmd); end
        checks++; if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'd0) begin failures++; $display("FAIL reset_ack_err got=%b exp=0000", {m0_ack, m1_ack, m0_err, m1_err}); end
        checks++; if ({m0_rdata, m1_rdata} !== 64'd0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0", m0_rdata, m1_rdata); end
        checks++; if (data_ !== KEEP) begin failures++; $display("FAIL reset_data_released got=%h exp=%h", data_, KEEP); end
        reset = 1'b0; mem_init = 1'b0;
    endtask

    task automatic test_single_read();
        m0_req = 1'b1; m0_cmd = bus_cmd_read_w; m0_addr = 16'h0020;
        step();
        checks++; if ({ce_n, addr, cmd, m0_ack} !== {1'b0, 16'h0020, bus_cmd_read_w, 1'b0}) begin failures++; $display("FAIL read_access got ce_n=%b addr=%h cmd=%h ack=%b exp 0/0020/3/0", ce_n, addr, cmd, m0_ack); end
        step();
        checks++; if ({m0_ack, m1_ack} !== 2'b10) begin failures++; $display("FAIL read_ack got m0=%b m1=%b exp 1/0", m0_ack, m1_ack); end
        checks++; if (m0_rdata !== 32'h0000BEEF || m1_rdata !== 32'd0) begin failures++; $display("FAIL read_rdata got m0=%h m1=%h exp 0000beef/0", m0_rdata, m1_rdata); end
        m0_req = 1'b0;
        step();
        checks++; if (ce_n !== 1'b1 || m0_ack !== 1'b0) begin failures++; $display("FAIL read_idle got ce_n=%b ack=%b exp 1/0", ce_n, m0_ack); end
    endtask

    task automatic test_wait();
        m0_req = 1'b1; m0_cmd = bus_cmd_read_w; m0_addr = 16'h0020; wait_n = 1'b0;
        step();
        for (int i = 1; i <= 4; i++) begin
            checks++; if ({ce_n, m0_ack, m0_err} !== 3'b000) begin failures++; $display("FAIL wait_hold%0d got ce_n=%b ack=%b err=%b exp 000", i, ce_n, m0_ack, m0_err); end
            step();
        end
        wait_n = 1'b1;
        checks++; if ({ce_n, m0_ack} !== 2'b00) begin failures++; $display("FAIL wait_release got ce_n=%b ack=%b exp 00", ce_n, m0_ack); end
        step();
        checks++; if ({m0_ack, m0_err, m0_rdata} !== {2'b10, 32'h0000BEEF}) begin failures++; $display("FAIL wait_ack got ack=%b err=%b rdata=%h exp 1/0/0000beef", m0_ack, m0_err, m0_rdata); end
        m0_req = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        m1_req = 1'b1; m1_cmd = bus_cmd_write_w; m1_addr = 16'h0040; m1_wdata = 32'h0000_1234;
        step();
        checks++; if ({ce_n, data_} !== {1'b0, 32'h1234}) begin failures++; $display("FAIL wr_access got ce_n=%b data=%h exp 0/1234", ce_n, data_); end
        step();
        checks++; if ({m1_ack, m0_ack, data_, m1_rdata} !== {2'b10, 32'h1234, 32'd0}) begin failures++; $display("FAIL wr_data got ack=%b/%b data=%h rdata=%h exp 1/0/1234/0", m1_ack, m0_ack, data_, m1_rdata); end
        m1_req = 1'b0;
        step();
        checks++; if ({ce_n, data_} !== {1'b1, KEEP}) begin failures++; $display("FAIL wr_idle_released got ce_n=%b data=%h exp 1/%h", ce_n, data_, KEEP); end
        m1_req = 1'b1; m1_cmd = bus_cmd_read_w;
        step(); step();
        checks++; if ({m1_ack, m1_rdata, m0_rdata} !== {1'b1, 32'h1234, 32'd0}) begin failures++; $display("FAIL rd_back got ack=%b rdata=%h m0_rdata=%h exp 1/1234/0", m1_ack, m1_rdata, m0_rdata); end
        m1_req = 1'b0;
        step();
    endtask

    task automatic test_contention();
        int last = 1;
        int o;
        logic [31:0] rd;
        do_reset();
        m0_req = 1'b1; m0_cmd = bus_cmd_read_w; m0_addr = 16'h0020;
        m1_req = 1'b1; m1_cmd = bus_cmd_read_w; m1_addr = 16'h0040;
        for (int k = 0; k < 6; k++) begin
            o = 1 - last;
            last = o;
            rd = (o == 0) ? 32'h0000BEEF : pat(32);
            step();
            checks++; if (addr !== (o == 0 ? 16'h0020 : 16'h0040)) begin failures++; $display("FAIL cont_grant%0d got addr=%h exp owner m%0d", k, addr, o); end
            step();
            checks++; if ({m1_ack, m0_ack} !== (o == 0 ? 2'b01 : 2'b10)) begin failures++; $display("FAIL cont_ack%0d got m1/m0=%b%b exp owner m%0d", k, m1_ack, m0_ack, o); end
            checks++; if ({m1_rdata, m0_rdata} !== (o == 0 ? {32'd0, rd} : {rd, 32'd0})) begin failures++; $display("FAIL cont_rdata%0d got m1=%h m0=%h exp owner m%0d=%h", k, m1_rdata, m0_rdata, o, rd); end
            if (k == 5) begin m0_req = 1'b0; m1_req = 1'b0; end
            step();
        end
    endtask

    task automatic test_timeout();
        m0_req = 1'b1; m0_cmd = bus_cmd_write_w; m0_addr = 16'h0060; m0_wdata = 32'h7777; wait_n = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            checks++; if ({ce_n, m0_ack, m0_err, m1_err} !== 4'd0) begin failures++; $display("FAIL tmo_wait%0d got ce_n=%b ack=%b err=%b/%b exp 0000", c, ce_n, m0_ack, m0_err, m1_err); end
        end
        step();
        checks++; if ({m0_err, m0_ack, m1_err, ce_n} !== 4'b1001) begin failures++; $display("FAIL tmo_err got err=%b ack=%b m1_err=%b ce_n=%b exp 1/0/0/1", m0_err, m0_ack, m1_err, ce_n); end
        m0_req = 1'b0; wait_n = 1'b1;
        m1_req = 1'b1; m1_cmd = bus_cmd_read_w; m1_addr = 16'h0040;
        step();
        checks++; if ({m0_err, ce_n, addr} !== {2'b00, 16'h0040}) begin failures++; $display("FAIL tmo_next got err=%b ce_n=%b addr=%h exp 0/0/0040", m0_err, ce_n, addr); end
        step();
        checks++; if ({m1_ack, m0_ack, m1_rdata} !== {2'b10, pat(32)}) begin failures++; $display("FAIL tmo_m1_served got ack=%b/%b rdata=%h exp 1/0/%h", m1_ack, m0_ack, m1_rdata, pat(32)); end
        m1_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        m1_req = 1'b1; m1_cmd = bus_cmd_write_w; m1_addr = 16'h0080; m1_wdata = 32'hCAFE;
        step(); step();
        checks++; if (m1_ack !== 1'b1) begin failures++; $display("FAIL rstmid_data got ack=%b exp 1", m1_ack); end
        reset = 1'b1;
        step();
        checks++; if ({ce_n, data_, m1_ack, m1_err, m0_ack, m0_err} !== {1'b1, KEEP, 4'd0}) begin failures++; $display("FAIL rstmid_after got ce_n=%b data=%h ack=%b err=%b exp 1/%h/0/0", ce_n, data_, m1_ack, m1_err, KEEP); end
        reset = 1'b0;
        m0_req = 1'b1; m0_cmd = bus_cmd_read_w; m0_addr = 16'h0020;
        m1_req = 1'b1; m1_cmd = bus_cmd_read_w; m1_addr = 16'h0040;
        step();
        checks++; if (addr !== 16'h0020) begin failures++; $display("FAIL rstmid_first_grant got addr=%h exp 0020", addr); end
        step();
        checks++; if ({m0_ack, m0_rdata} !== {1'b1, 32'h0000BEEF}) begin failures++; $display("FAIL rstmid_m0 got ack=%b rdata=%h exp 1/0000beef", m0_ack, m0_rdata); end
        m0_req = 1'b0;
        step(); step(); step();
        checks++; if ({m1_ack, m1_rdata} !== {1'b1, pat(32)}) begin failures++; $display("FAIL rstmid_m1 got ack=%b rdata=%h exp 1/%h", m1_ack, m1_rdata, pat(32)); end
        m1_req = 1'b0;
        step();
    endtask

    task automatic test_random();
        int last = 1;
        int first, o, n, w;
        logic [1:0] p;
        logic [15:0] a [2];
        logic [2:0] c [2];
        logic [31:0] d [2];
        logic [31:0] rd;
        do_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        for (int r = 0; r < 40; r++) begin
            p = 2'($urandom_range(1, 3));
            w = $urandom_range(0, 3);
            for (int m = 0; m < 2; m++) begin
                a[m] = 16'($urandom_range(0, 31) * 2);
                c[m] = $urandom_range(0, 1) ? bus_cmd_read_w : bus_cmd_write_w;
                d[m] = $urandom;
            end
            m0_addr = a[0]; m0_cmd = c[0]; m0_wdata = d[0];
            m1_addr = a[1]; m1_cmd = c[1]; m1_wdata = d[1];
            m0_req = p[0]; m1_req = p[1];
            first = (p == 2'b11) ? 1 - last : (p == 2'b10 ? 1 : 0);
            n = (p == 2'b11) ? 2 : 1;
            for (int k = 0; k < n; k++) begin
                o = (k == 0) ? first : 1 - first;
                last = o;
                wait_n = (w == 0);
                step();
                rd = c[o][0] ? ref_mem[a[o][8:1]] : d[o];
                checks++; if ({ce_n, addr, cmd, data_} !== {1'b0, a[o], c[o], rd}) begin failures++; $display("FAIL rnd%0d_access got ce_n=%b addr=%h cmd=%h data=%h exp m%0d 0/%h/%h/%h", r, ce_n, addr, cmd, data_, o, a[o], c[o], rd); end
                for (int i = 1; i <= w; i++) begin
                    step();
                    checks++; if ({ce_n, m0_ack, m1_ack} !== 3'b000) begin failures++; $display("FAIL rnd%0d_wait%0d got ce_n=%b ack=%b%b exp 000", r, i, ce_n, m1_ack, m0_ack); end
                    wait_n = (i == w);
                end
                step();
                rd = c[o][0] ? ref_mem[a[o][8:1]] : 32'd0;
                checks++; if ({m1_ack, m0_ack, m1_err, m0_err} !== (o == 0 ? 4'b0100 : 4'b1000)) begin failures++; $display("FAIL rnd%0d_ack got ack=%b%b err=%b%b exp owner m%0d", r, m1_ack, m0_ack, m1_err, m0_err, o); end
                checks++; if ({m1_rdata, m0_rdata} !== (o == 0 ? {32'd0, rd} : {rd, 32'd0})) begin failures++; $display("FAIL rnd%0d_rdata got m1=%h m0=%h exp m%0d=%h", r, m1_rdata, m0_rdata, o, rd); end
                if (!c[o][0]) ref_mem[a[o][8:1]] = d[o];
                if (o == 0) m0_req = 1'b0; else m1_req = 1'b0;
                wait_n = 1'b1;
                step();
                checks++; if ({ce_n, data_} !== {1'b1, KEEP}) begin failures++; $display("FAIL rnd%0d_idle got ce_n=%b data=%h exp 1/%h", r, ce_n, data_, KEEP); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_wait();
        test_write_read();
        test_contention();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/h80bus_arbiter.md
Name: h80bus_arbiter

Overview:
- Two-master arbiter for the h80 memory bus.
- Shares one bus slave (the h80 memory block, ce_n/addr/cmd/data_/wait_n) between master 0 (CPU) and master 1 (DMA/debug loader).
- Grants round-robin, sequences each transfer as ACCESS then DATA phase, honours slave wait_n, and aborts with an error after a wait timeout.
- Masters see a simple req/ack interface with separate write and read data.

Parameters:
BUS_ADDR_WIDTH, 16, address width on masters and slave
BUS_CMD_WIDTH, 3, command width; encodings come from the shared h80bus definitions
BUS_DATA_WIDTH, 32, data width (32 needed for 32-bit bus_cmd_read/bus_cmd_write)
WAIT_TIMEOUT, 255, max consecutive wait_n-low cycles in ACCESS before abort

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
m0_req  in  1  master 0 request; addr/cmd/wdata held stable while high
m0_addr  in  BUS_ADDR_WIDTH  master 0 address
m0_cmd  in  BUS_CMD_WIDTH  master 0 command
m0_wdata  in  BUS_DATA_WIDTH  master 0 write data
m0_ack  out  1  master 0 transfer complete, high one cycle
m0_err  out  1  master 0 timeout abort, high one cycle, mutually exclusive with ack
m0_rdata  out  BUS_DATA_WIDTH  master 0 read data, valid while m0_ack high
m1_req, m1_addr, m1_cmd, m1_wdata, m1_ack, m1_err, m1_rdata  same as master 0, for master 1
ce_n  out  1  slave chip enable, active low
addr  out  BUS_ADDR_WIDTH  slave address
cmd  out  BUS_CMD_WIDTH  slave command
data_  inout  BUS_DATA_WIDTH  slave data; driven only for write commands (cmd[0]==0) while ce_n low, else 'z
wait_n  in  1  slave ready, active low wait

Behaviour:
- Reset outputs: ce_n=1, addr=0, cmd=0, data_='z, all ack/err=0, rdata=0; state IDLE; rr_last=1 (master 0 wins the first tie); timeout counter 0.
- States: IDLE, ACCESS, DATA.
- IDLE:
  - ce_n=1.
  - At the clock edge, if any req is high, latch the grant into owner and go to ACCESS.
  - Single request: grant that master.
  - Both high: grant the master other than rr_last.
  - Update rr_last to owner.
- ACCESS:
  - ce_n=0; addr/cmd come from the owner's inputs.
  - data_ = owner wdata when cmd[0]==0.
  - wait_n==1 at the edge: go to DATA and clear the counter.
  - wait_n==0: stay and increment the counter.
  - Counter reaches WAIT_TIMEOUT: go to IDLE and pulse owner err during the following IDLE cycle; no ack.
- DATA:
  - ce_n, addr, cmd and data_ are the same as in ACCESS.
  - Owner ack=1 combinationally; owner rdata = data_ when cmd[0]==1, else 0.
  - Non-owner ack=0, rdata=0.
  - Next state IDLE unconditionally; wait_n is ignored in DATA.
- Masters clear req on the edge where they see ack/err. IDLE therefore always sees the fresh req.
- Minimum transfer is 3 cycles (ACCESS, DATA, IDLE). Read data is valid exactly in the DATA cycle.
- A write is presented to the slave for two consecutive ce_n-low edges. Slave writes are idempotent, so this is permitted.
- Fairness:
  - Both masters requesting continuously alternate grants 0,1,0,1…
  - A lone requester is granted on every IDLE.
- A req dropping mid-transfer does not abort the transfer; ack still pulses.
- Reset in ACCESS or DATA: next cycle is IDLE, ce_n=1, data_='z, no ack/err emitted, rr_last=1.
- ack and err are never high for both masters in the same cycle.
- Under no condition does the arbiter drive data_ during a read command or while ce_n=1.

Decomposition:
- Shared package h80bus_pkg holds:
  - bus_cmd_* command constants (read, write, read_w, write_w, read_b, write_b)
  - function is_read(cmd) = cmd[0]
  - arbiter state enum {IDLE, ACCESS, DATA}
- One sub-module: h80bus_rr_grant.
  - Pure combinational 2-way round-robin picker: inputs req[1:0] and rr_last; outputs grant_valid and grant_idx.
  - Keeps the picker reusable for a future N-master version.

Test Plan:
- Single read:
  - Slave mem[0x10]=0xBEEF. m0 req read_w addr 0x0020.
  - ACCESS at cycle 1 and DATA at cycle 2.
  - m0_ack=1 with m0_rdata=0x0000BEEF in cycle 2; ce_n high in cycle 3.
- Write then read:
  - m1 write_w addr 0x0040 wdata 0x1234, then m1 read_w 0x0040.
  - data_ driven 0x1234 only while ce_n low.
  - The read returns 0x1234 on the second ack.
- Contention:
  - m0 and m1 both hold req for 6 transfers from reset.
  - Grant order is 0,1,0,1,0,1; each ack lands on the correct master; rdata of the non-owner stays 0.
- Wait states:
  - Slave holds wait_n=0 for 4 cycles in ACCESS.
  - ce_n stays low, ack arrives in the cycle after wait_n returns high, no err.
- Timeout:
  - WAIT_TIMEOUT=8 and wait_n stuck low.
  - m0_err pulses once 9 cycles after grant, m0_ack never rises.
  - ce_n returns high and m1 is then served normally.
- Reset mid-transfer:
  - Assert reset during DATA of an m1 write.
  - Next cycle ce_n=1, data_='z, no ack.
  - After release, simultaneous requests grant m0 first.
